fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequencer for the instruction fetch stage of the pipelined processor. Drives the PC and read enable of the byte-organised instruction memory, registers each fetched 8-bit instruction into a one-deep valid/ready output stage toward decode, and applies PC redirects, jump handling and end-of-memory halt. Sits between instruction memory and the IF/ID pipeline register.

## Interface
- ADDR_W, 8, PC/address width
- INSTR_W, 8, instruction width
- MEM_DEPTH, 36, number of valid memory locations; addresses ≥ MEM_DEPTH are out of range
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins fetch at PC 0
- imem_pc  out  ADDR_W  address to instruction memory
- imem_en  out  1  memory read enable; low = memory in its initialise state, high = read
- imem_instr  in  INSTR_W  byte returned combinationally for imem_pc
- redirect_valid  in  1  downstream PC redirect request
- redirect_pc  in  ADDR_W  redirect target
- out_valid  out  1  out_instr/out_pc hold a valid instruction
- out_ready  in  1  decode accepts this cycle
- out_instr  out  INSTR_W  registered instruction
- out_pc  out  ADDR_W  address of out_instr
- halt  out  1  controller in HALT

## Operation
- States: IDLE, RUN, HALT. Reset → IDLE.
- IDLE: imem_en=0, out_valid=0. start → RUN, PC=0.
- RUN: imem_en=1. Output stage is "free" when !out_valid or out_ready. When free, load out_instr=imem_instr, out_pc=PC, out_valid=1, PC=PC+1. When not free, hold PC and outputs unchanged.
- PC+1 equal to MEM_DEPTH: last word loaded, then → HALT; out_valid stays 1 until accepted.
- Redirect (priority over everything in RUN): out_valid cleared next cycle (flush, even if out_ready), PC=redirect_pc. redirect_pc ≥ MEM_DEPTH → HALT with out_valid=0.
- Opcode field bits [7:6]: 00 add, 01 sll, 11 jump (target = {2'b00, bits[5:0]}). 0x00 is nop, passed through like any instruction.
- HALT: imem_en=0, halt=1, PC frozen; pending output word drains on out_ready. redirect_valid ignored. start → RUN at PC 0 (pending word discarded). Only reset or start leaves HALT.
- start in RUN: ignored.
- reset in any state, any cycle: all outputs to reset values next edge, pending word discarded.

## Timing
- Reset values: imem_pc=0, imem_en=0, out_valid=0, out_instr=0, out_pc=0, halt=0; state IDLE.
- start at cycle N → imem_en=1 at N+1, first out_valid at N+2.
- Throughput 1 instruction/cycle with out_ready held high.
- Redirect asserted cycle N → PC=target at N+1, target instruction valid at N+2 (one bubble).
- PC arithmetic modulo 2^ADDR_W; range check against MEM_DEPTH precedes any wrap, so wrap never occurs in RUN.
- out_instr/out_pc stable whenever out_valid && !out_ready.

## Configuration
- FETCH_EARLY_JUMP_EN defined: when free and imem_instr[7:6]==11, jump is consumed in fetch: PC=target next cycle, nothing loaded (out_valid=0 if it was free by acceptance), one bubble; target ≥ MEM_DEPTH → HALT. Simultaneous redirect_valid wins.
- Undefined: jumps pass downstream as ordinary instructions; decode resolves them via redirect_valid.

## Structure
- Package fetch_pkg: state enum (IDLE, RUN, HALT), opcode constants OP_ADD=2'b00, OP_SLL=2'b01, OP_J=2'b11, NOP=8'h00, default MEM_DEPTH.
- Single module; no sub-module needed.

## Test plan
- Memory 1B,59,1B,C5,5B,3B,00; macro off; start, out_ready=1 → out_pc 0..6 with those bytes, one per cycle, then continues to 35, halt=1.
- Same image, macro on → out stream 1B@0,59@1,1B@2, bubble, 3B@5,00@6; 0xC5 never presented.
- out_ready low 3 cycles while out_pc=1 → out_instr=59/out_pc=1 held, imem_pc=2 held; resumes with 1B@2 on release.
- redirect_valid with redirect_pc=4 while out_pc=1 pending → pending flushed, next valid is 5B@4; redirect_pc=40 → halt=1, out_valid=0.
- Redirect and early jump same cycle (macro on, redirect_pc=0) → PC=0, jump ignored.
- reset mid-RUN at out_pc=3 → next cycle all outputs zero, state IDLE; start → refetch from 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// opcode field values and the default instruction memory depth.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_J   = 2'b11;
  localparam logic [7:0] NOP    = 8'h00;

  localparam int DEFAULT_MEM_DEPTH = 36;

  function automatic logic is_jump(input logic [1:0] opcode);
    return (opcode == OP_J);
  endfunction

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: drives the byte memory PC/enable and feeds a
// one-deep valid/ready stage toward decode. Define FETCH_EARLY_JUMP_EN to resolve jumps inside fetch.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int INSTR_W   = 8,
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_pc,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halt
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_HALT = ST_HALT;

  // One extra bit so the end-of-memory test happens before any PC wrap.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);

  logic [1:0]         state_r;
  logic [1:0]         state_s;
  logic [ADDR_W-1:0]  pc_r;
  logic [ADDR_W-1:0]  pc_s;
  logic               out_valid_r;
  logic               out_valid_s;
  logic [INSTR_W-1:0] out_instr_r;
  logic [INSTR_W-1:0] out_instr_s;
  logic [ADDR_W-1:0]  out_pc_r;
  logic [ADDR_W-1:0]  out_pc_s;
  logic               imem_en_r;
  logic               halt_r;

  logic               free_s;
  logic [ADDR_W:0]    pc_inc_s;
  logic [ADDR_W-1:0]  jump_tgt_s;
  logic               take_jump_s;

  assign free_s     = ~out_valid_r | out_ready;
  assign pc_inc_s   = {1'b0, pc_r} + {{ADDR_W{1'b0}}, 1'b1};
  assign jump_tgt_s = ADDR_W'(imem_instr[5:0]);

`ifdef FETCH_EARLY_JUMP_EN
  assign take_jump_s = is_jump(imem_instr[INSTR_W-1 -: 2]);
`else
  assign take_jump_s = 1'b0;
`endif

  // Next-state, PC and output-stage decisions for the fetch FSM.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    out_valid_s = out_valid_r;
    out_instr_s = out_instr_r;
    out_pc_s    = out_pc_r;
    case (state_r)
      S_IDLE: begin
        out_valid_s = 1'b0;
        if (start) begin
          state_s = S_RUN;
          pc_s    = {ADDR_W{1'b0}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (redirect_valid) begin
          // Redirect flushes the pending word even if decode takes it now.
          out_valid_s = 1'b0;
          pc_s        = redirect_pc;
          if ({1'b0, redirect_pc} >= DEPTH_X) begin
            state_s = S_HALT;
          end else begin
            state_s = S_RUN;
          end
        end else if (free_s) begin
          if (take_jump_s) begin
            out_valid_s = 1'b0;
            pc_s        = jump_tgt_s;
            if ({1'b0, jump_tgt_s} >= DEPTH_X) begin
              state_s = S_HALT;
            end else begin
              state_s = S_RUN;
            end
          end else begin
            out_instr_s = imem_instr;
            out_pc_s    = pc_r;
            out_valid_s = 1'b1;
            pc_s        = pc_inc_s[ADDR_W-1:0];
            if (pc_inc_s == DEPTH_X) begin
              state_s = S_HALT;
            end else begin
              state_s = S_RUN;
            end
          end
        end else begin
          state_s = S_RUN;
        end
      end
      S_HALT: begin
        if (start) begin
          state_s     = S_RUN;
          pc_s        = {ADDR_W{1'b0}};
          out_valid_s = 1'b0;
        end else begin
          state_s = S_HALT;
          if (out_valid_r && out_ready) begin
            out_valid_s = 1'b0;
          end else begin
            out_valid_s = out_valid_r;
          end
        end
      end
      default: begin
        state_s     = S_IDLE;
        pc_s        = {ADDR_W{1'b0}};
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      pc_r        <= {ADDR_W{1'b0}};
      out_valid_r <= 1'b0;
      out_instr_r <= {INSTR_W{1'b0}};
      out_pc_r    <= {ADDR_W{1'b0}};
      imem_en_r   <= 1'b0;
      halt_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      out_valid_r <= out_valid_s;
      out_instr_r <= out_instr_s;
      out_pc_r    <= out_pc_s;
      imem_en_r   <= (state_s == S_RUN);
      halt_r      <= (state_s == S_HALT);
    end
  end

  assign imem_pc   = pc_r;
  assign imem_en   = imem_en_r;
  assign out_valid = out_valid_r;
  assign out_instr = out_instr_r;
  assign out_pc    = out_pc_r;
  assign halt      = halt_r;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_fetch_controller;

`ifdef FETCH_EARLY_JUMP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int DEPTH = 36;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] imem_pc;
  logic       imem_en;
  logic [7:0] imem_instr;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_instr;
  logic [7:0] out_pc;
  logic       halt;

  logic [7:0] mem [0:255];
  assign imem_instr = mem[imem_pc];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 run, 2 halt; pq holds {pc, instr} of the word shown to decode.
  int          m_mode = 0;
  int          m_pc = 0;
  logic [15:0] pq [$];

  fetch_controller dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_pc(imem_pc), .imem_en(imem_en), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic [7:0] w;
    if (reset) begin
      m_mode = 0; m_pc = 0; pq.delete();
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; m_pc = 0; end
        1: begin
          if (pq.size() != 0 && out_ready) void'(pq.pop_front());
          if (redirect_valid) begin
            pq.delete();
            m_pc = int'(redirect_pc);
            if (m_pc >= DEPTH) m_mode = 2;
          end else if (pq.size() == 0) begin
            w = mem[m_pc];
            if (EARLY && w[7:6] == 2'b11) begin
              m_pc = int'(w[5:0]);
              if (m_pc >= DEPTH) m_mode = 2;
            end else begin
              pq.push_back({8'(m_pc), w});
              m_pc = m_pc + 1;
              if (m_pc == DEPTH) m_mode = 2;
            end
          end
        end
        default: begin
          if (start) begin
            m_mode = 1; m_pc = 0; pq.delete();
          end else if (pq.size() != 0 && out_ready) begin
            void'(pq.pop_front());
          end
        end
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic load_image();
    logic [7:0] img [0:6];
    img = '{8'h1B, 8'h59, 8'h1B, 8'hC5, 8'h5B, 8'h3B, 8'h00};
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    for (int i = 0; i < 7; i++) mem[i] = img[i];
    for (int i = 7; i < DEPTH; i++) mem[i] = 8'($urandom) & 8'h7F;
  endtask

  task automatic start_fetch();
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0;
    cycle();
    reset = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_pc(input logic [7:0] p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (out_valid && out_pc == p) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    n_vec++;
    if ({imem_pc, imem_en, out_valid, out_instr, out_pc, halt} !== 28'h0) begin
      n_err++;
      $display("FAIL reset_values: got pc=%0h en=%b v=%b i=%0h opc=%0h h=%b want all 0",
               imem_pc, imem_en, out_valid, out_instr, out_pc, halt);
    end
    reset = 1'b0;
    cycle();
    n_vec++;
    if ({imem_en, out_valid, halt} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_hold: got en=%b v=%b h=%b want 000", imem_en, out_valid, halt);
    end
  endtask

  task automatic test_stream();
    logic [15:0] got [$];
    logic [15:0] exp [$];
    int first, last;
    first = -1; last = -1;
    load_image();
    out_ready = 1'b1;
    start_fetch();
    n_vec++;
    if ({imem_en, out_valid, imem_pc} !== {1'b1, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL start_latency: got en=%b v=%b pc=%0d want en=1 v=0 pc=0", imem_en, out_valid, imem_pc);
    end
    for (int i = 0; i < 80; i++) begin
      cycle();
      if (out_valid) begin
        got.push_back({out_pc, out_instr});
        if (first < 0) first = i;
        last = i;
      end
      if (halt && !out_valid) break;
    end
    for (int p = 0; p < DEPTH; p++) begin
      if (!(EARLY && (p == 3 || p == 4))) exp.push_back({8'(p), mem[p]});
    end
    n_vec++;
    if (got.size() != exp.size()) begin
      n_err++;
      $display("FAIL stream_len: got %0d words want %0d", got.size(), exp.size());
    end else begin
      for (int k = 0; k < exp.size(); k++) begin
        n_vec++;
        if (got[k] !== exp[k]) begin
          n_err++;
          $display("FAIL stream_word[%0d]: got %0h@%0d want %0h@%0d", k, got[k][7:0], got[k][15:8], exp[k][7:0], exp[k][15:8]);
        end
      end
    end
    n_vec++;
    if (first != 0 || (last - first) != (exp.size() - 1 + (EARLY ? 1 : 0))) begin
      n_err++;
      $display("FAIL stream_timing: got first=%0d span=%0d want first=0 span=%0d", first, last - first, exp.size() - 1 + (EARLY ? 1 : 0));
    end
    n_vec++;
    if ({halt, imem_en} !== 2'b10) begin
      n_err++;
      $display("FAIL stream_halt: got halt=%b en=%b want halt=1 en=0", halt, imem_en);
    end
  endtask

  task automatic test_halt_start();
    redirect_valid = 1'b1; redirect_pc = 8'd2;
    cycle();
    redirect_valid = 1'b0;
    n_vec++;
    if ({halt, imem_en, out_valid, imem_pc} !== {1'b1, 1'b0, 1'b0, 8'd36}) begin
      n_err++;
      $display("FAIL halt_ignores_redirect: got h=%b en=%b v=%b pc=%0d want h=1 en=0 v=0 pc=36", halt, imem_en, out_valid, imem_pc);
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    n_vec++;
    if ({halt, imem_en, out_valid, imem_pc} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL halt_restart: got h=%b en=%b v=%b pc=%0d want h=0 en=1 v=0 pc=0", halt, imem_en, out_valid, imem_pc);
    end
    cycle();
    n_vec++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 8'd0, 8'h1B}) begin
      n_err++;
      $display("FAIL halt_restart_word: got v=%b %0h@%0d want 1b@0", out_valid, out_instr, out_pc);
    end
  endtask

  task automatic test_stall();
    bit ok;
    load_image();
    out_ready = 1'b1;
    start_fetch();
    run_until_pc(8'd1, ok);
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL stall_reach: got no word@1 want word@1"); end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_vec++;
      if ({out_valid, out_pc, out_instr, imem_pc} !== {1'b1, 8'd1, 8'h59, 8'd2}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%b %0h@%0d pc=%0d want 59@1 pc=2", i, out_valid, out_instr, out_pc, imem_pc);
      end
    end
    out_ready = 1'b1;
    cycle();
    n_vec++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 8'd2, 8'h1B}) begin
      n_err++;
      $display("FAIL stall_release: got v=%b %0h@%0d want 1b@2", out_valid, out_instr, out_pc);
    end
  endtask

  task automatic test_redirect();
    bit ok;
    load_image();
    out_ready = 1'b1;
    start_fetch();
    run_until_pc(8'd1, ok);
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL redirect_reach: got no word@1 want word@1"); end
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 8'd4;
    cycle();
    redirect_valid = 1'b0;
    n_vec++;
    if ({out_valid, imem_pc} !== {1'b0, 8'd4}) begin
      n_err++;
      $display("FAIL redirect_flush: got v=%b pc=%0d want v=0 pc=4", out_valid, imem_pc);
    end
    out_ready = 1'b1;
    cycle();
    n_vec++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 8'd4, 8'h5B}) begin
      n_err++;
      $display("FAIL redirect_target: got v=%b %0h@%0d want 5b@4", out_valid, out_instr, out_pc);
    end
    redirect_valid = 1'b1; redirect_pc = 8'd40;
    cycle();
    redirect_valid = 1'b0;
    n_vec++;
    if ({halt, out_valid, imem_en} !== 3'b100) begin
      n_err++;
      $display("FAIL redirect_oob: got h=%b v=%b en=%b want h=1 v=0 en=0", halt, out_valid, imem_en);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    load_image();
    out_ready = 1'b1;
    start_fetch();
    run_until_pc(EARLY ? 8'd5 : 8'd3, ok);
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL midreset_reach: got no target word want it"); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_vec++;
    if ({imem_pc, imem_en, out_valid, out_instr, out_pc, halt} !== 28'h0) begin
      n_err++;
      $display("FAIL midreset_values: got pc=%0h en=%b v=%b i=%0h opc=%0h h=%b want all 0",
               imem_pc, imem_en, out_valid, out_instr, out_pc, halt);
    end
    cycle();
    n_vec++;
    if ({imem_en, out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL midreset_idle: got en=%b v=%b want 00", imem_en, out_valid);
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    n_vec++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 8'd0, 8'h1B}) begin
      n_err++;
      $display("FAIL midreset_refetch: got v=%b %0h@%0d want 1b@0", out_valid, out_instr, out_pc);
    end
  endtask

`ifdef FETCH_EARLY_JUMP_EN
  task automatic test_jump_redirect();
    bit ok;
    load_image();
    out_ready = 1'b1;
    start_fetch();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_pc == 8'd3) begin ok = 1'b1; break; end
      cycle();
    end
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL jumpredir_reach: got no pc=3 want pc=3"); end
    redirect_valid = 1'b1; redirect_pc = 8'd0;
    cycle();
    redirect_valid = 1'b0;
    n_vec++;
    if ({imem_pc, out_valid, halt} !== {8'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL jumpredir_pc: got pc=%0d v=%b h=%b want pc=0 v=0 h=0", imem_pc, out_valid, halt);
    end
    cycle();
    n_vec++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 8'd0, 8'h1B}) begin
      n_err++;
      $display("FAIL jumpredir_word: got v=%b %0h@%0d want 1b@0", out_valid, out_instr, out_pc);
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] head;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    reset = 1'b1;
    cycle();
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 99) == 0);
      start          = ($urandom_range(0, 19) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = 8'($urandom_range(0, 40));
      out_ready      = ($urandom_range(0, 3) != 0);
      cycle();
      n_vec++;
      if ({imem_pc, imem_en, halt, out_valid} !== {8'(m_pc), m_mode == 1, m_mode == 2, pq.size() != 0}) begin
        n_err++;
        $display("FAIL rand_ctrl[%0d]: got pc=%0d en=%b h=%b v=%b want pc=%0d mode=%0d v=%b",
                 n, imem_pc, imem_en, halt, out_valid, m_pc, m_mode, pq.size() != 0);
      end
      if (pq.size() != 0) begin
        head = pq[0];
        n_vec++;
        if ({out_pc, out_instr} !== head) begin
          n_err++;
          $display("FAIL rand_word[%0d]: got %0h@%0d want %0h@%0d", n, out_instr, out_pc, head[7:0], head[15:8]);
        end
      end
    end
    reset = 1'b0; start = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_halt_start();
    test_stall();
    test_redirect();
    test_reset_mid();
`ifdef FETCH_EARLY_JUMP_EN
    test_jump_redirect();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
